// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Register-file write-port arbiter (pipeline writeback first,
//            buffered multi-cycle results second) with a pending-destination
//            scoreboard for decode hazard stalls.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_w,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_w,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        iss_long,
    input  logic [4:0]  iss_w,
    input  logic [4:0]  q_a,
    input  logic [4:0]  q_b,
    input  logic [4:0]  q_d,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_w,
    output logic [31:0] rf_data,
    output logic [30:0] pending
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [4:0]      r_mem_w    [DEPTH];
    logic [31:0]     r_mem_data [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [30:0]     r_pending;

    logic        w_empty;
    logic        w_full;
    logic        w_wb_grant;
    logic        w_fifo_grant;
    logic        w_push;
    logic [30:0] w_set;
    logic [30:0] w_clr;
    logic [31:0] w_pend_ext;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);
    assign lu_ready = !w_full;

    // rf_we must drop while rst is asserted even though wb_* may still be active.
    assign w_wb_grant   = !rst && wb_we && (wb_w != 5'd0);
    assign w_fifo_grant = !rst && !w_wb_grant && !w_empty;

    // Results for r0 are handshaken but never stored.
    assign w_push = lu_valid && lu_ready && (lu_w != 5'd0);

    always_comb begin
        rf_we   = 1'b0;
        rf_w    = 5'd0;
        rf_data = 32'd0;
        if (w_wb_grant) begin
            rf_we   = 1'b1;
            rf_w    = wb_w;
            rf_data = wb_data;
        end else if (w_fifo_grant) begin
            rf_we   = 1'b1;
            rf_w    = r_mem_w[r_rd_ptr];
            rf_data = r_mem_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_w[r_wr_ptr]    <= lu_w;
            r_mem_data[r_wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_fifo_grant) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_fifo_grant);
        end
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 1; i < 32; i++) begin
            w_set[i-1] = iss_long && (iss_w == 5'(i));
            w_clr[i-1] = w_fifo_grant && (rf_w == 5'(i));
        end
    end

    // Set is applied after clear so a same-cycle set/clear leaves the bit high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    assign pending    = r_pending;
    assign w_pend_ext = {r_pending, 1'b0};
    assign stall      = w_pend_ext[q_a] | w_pend_ext[q_b] | w_pend_ext[q_d];

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 31-entry general register file. The single register-file write port is shared between the in-order pipeline writeback and results returned by the multi-cycle unit (mul/div). The pipeline writeback always has priority. Multi-cycle results are buffered in a small FIFO and drained on idle write cycles. A pending-destination scoreboard tells the decode stage when to stall on RAW/WAW hazards against outstanding multi-cycle results.

## Interface
Parameters:
- DEPTH, 2, multi-cycle result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous reset, active-high
- wb_we  in  1  pipeline writeback enable
- wb_w  in  5  pipeline writeback destination
- wb_data  in  32  pipeline writeback data
- lu_valid  in  1  multi-cycle unit result valid
- lu_w  in  5  multi-cycle result destination
- lu_data  in  32  multi-cycle result data
- lu_ready  out  1  FIFO can accept a result
- iss_long  in  1  decode issues a multi-cycle op this cycle (already hazard-free)
- iss_w  in  5  destination of that op
- q_a, q_b, q_d  in  5 each  decode source A, source B, destination (0 = unused)
- stall  out  1  decode must hold
- rf_we  out  1  register-file write enable
- rf_w  out  5  register-file write index
- rf_data  out  32  register-file write data
- pending  out  31  scoreboard bit per r1..r31 (bit i-1 = ri)

## Operation
- The write path is combinational from the inputs and the FIFO head.
- Grant: if wb_we && wb_w≠0, then rf_* = wb_*. Else, if the FIFO is non-empty, rf_* = head and the head pops at the edge. Else rf_we=0.
- A destination of 0 is never a write: wb writes to r0 are dropped, and lu results to r0 are accepted and discarded (never enqueued).
- FIFO push when lu_valid && lu_ready. lu_ready = !full (registered count). Push and pop in the same cycle are legal when full: the pop does not free space for a same-cycle push; lu_ready stays low that cycle.
- Pipeline writeback is never held. Continuous wb traffic may hold the FIFO indefinitely; lu_ready deasserts when full.
- Scoreboard set: iss_long && iss_w≠0 sets pending[iss_w] at the edge.
- Scoreboard clear: pending[rf_w] clears at the edge when the FIFO head is granted.
- If the same register is set and cleared in the same cycle, set wins.
- stall = pending[q_a] | pending[q_b] | pending[q_d]; an index of 0 never stalls. Stall is computed from registered pending only, with no same-cycle clear bypass (conservative).
- Decode guarantees iss_long never targets a pending register, because the WAW check via q_d prevents it. A duplicate set is harmless (bit stays 1).
- Data forwarding on the same-cycle write is handled by the register file itself; this block adds no forwarding.

## Timing
- Reset (async, immediate): FIFO empty, pending=0, lu_ready=1, stall=0.
- rf_we is forced 0 while rst is high, independent of wb_we.
- A result accepted at edge N is visible on rf_* no earlier than the cycle after N, and writes at edge N+1 if wb is idle. There is no FIFO bypass.
- The pending bit drops at the same edge the register file captures the data. stall deasserts the following cycle.
- wb grant has zero-cycle latency: rf_* follows wb_* combinationally.
- FIFO pointers wrap modulo DEPTH. The count ranges 0..DEPTH.
- Reset mid-operation discards buffered results and pending bits. The pipeline is flushed by the same reset.

## Test plan
- Reset, then wb_we=1, wb_w=5, wb_data=0x1234 → rf_we=1, rf_w=5, rf_data=0x1234 that cycle; with rst held high, rf_we=0.
- iss_long with iss_w=7. Next cycle q_a=7 → stall=1. Then lu_valid with lu_w=7 and lu_data=0xDEAD while wb idle → written one cycle after acceptance, pending[6]=0 at that edge, stall=0 the following cycle.
- wb_we=1 continuously while pushing three lu results (DEPTH=2) → lu_ready=0 after two accepts. The third is held by the producer. Drop wb_we → FIFO drains in order, one write per cycle.
- Full FIFO with simultaneous pop and lu_valid → pop occurs, push refused (lu_ready=0). Next cycle lu_ready=1 and the push is accepted.
- wb_w=0 with wb_we=1 while the FIFO holds a result → FIFO head granted. lu_w=0 result → accepted, never written, no pending change.
- q_a=0, q_b=0, q_d=0 with all pending=1 → stall=0. Assert rst mid-drain → pending=0, FIFO empty, lu_ready=1 immediately.
